sio_tx_sched: RTL
=================

Name: sio_tx_sched

Overview:
Word-level transmit scheduler for the serial I/O path.
- Shares one byte-wide UART transmit channel (vld_tx/rdy_tx/d_tx, feeding tx) between NREQ word producers, e.g. the CPU put register and an rx echo path.
- Grants whole words round-robin, serializes each granted word into WIDTH/8 bytes and never interleaves bytes of different words.
- Replaces a fixed single-source puts stage when more than one producer needs the link.

Parameters:
NREQ, 2, number of word requesters (2..8)
WIDTH, 32, word width in bits; must be a multiple of 8
LSB_FIRST, 1, 1 = send byte [7:0] first; 0 = send byte [WIDTH-1:WIDTH-8] first

Ports:
clk  in  1  system clock (the tx bit-rate domain clock)
rst  in  1  asynchronous, active-high reset
req_vld  in  NREQ  requester i has a word pending
req_data  in  NREQ*WIDTH  word of requester i at slice [i*WIDTH +: WIDTH]
req_rdy  out  NREQ  one-hot; word i is accepted on a clk edge where req_vld[i] & req_rdy[i]
d_tx  out  8  byte to transmitter
vld_tx  out  1  d_tx valid
rdy_tx  in  1  transmitter accepts byte on edge where vld_tx & rdy_tx
busy  out  1  word in flight (state SEND)
gnt_id  out  $clog2(NREQ)  index of last granted requester

Behaviour:
- Reset values (async assert, all outputs): vld_tx=0, d_tx=0, req_rdy=0, busy=0, gnt_id=0. Internal last-grant pointer = NREQ-1, so requester 0 wins first. Byte counter = 0.
- Reset mid-word aborts the word. No partial bytes are resent after reset release.
- FSM has two states:
  - IDLE: if any req_vld, pick winner w = first set bit scanning from (ptr+1) mod NREQ upward with wrap. req_rdy is one-hot at w, combinational, valid only in IDLE. On that edge: capture req_data[w] into the shift register, set ptr=gnt_id=w, cnt=WIDTH/8-1, go to SEND. If no req_vld: stay, req_rdy=0.
  - SEND: vld_tx=1, busy=1, d_tx = current byte of the shift register (low byte if LSB_FIRST, else high byte).
    - On vld_tx&rdy_tx with cnt≠0: shift by 8, cnt-=1, stay in SEND.
    - On vld_tx&rdy_tx with cnt=0: go to IDLE, vld_tx=0 next cycle.
    - With rdy_tx=0: d_tx and vld_tx hold stable.
- Latency:
  - Grant to first byte presented: 1 cycle.
  - One bubble cycle in IDLE between words. Back-to-back words cost 4 byte transfers + 1 cycle each.
- Requesters may deassert req_vld freely before grant. A word is committed only on the handshake edge.
- Fairness: a requester with continuously asserted req_vld is granted within NREQ words.
- Simultaneous requests: ptr decides. Example with NREQ=2 and both held high: grants alternate 0,1,0,1.
- Requests arriving during SEND are held off (req_rdy=0) and arbitrated when the FSM returns to IDLE.
- rdy_tx may stay high continuously: one byte per cycle.
- rdy_tx high while vld_tx=0 has no effect.
- Only one bit of req_rdy is ever high. req_rdy is all zeros in SEND.

Decomposition:
- Package sio_pkg holds:
  - state enum {S_IDLE, S_SEND}
  - localparam BYTES = WIDTH/8
  - function for the pointer width ($clog2 with a minimum of 1)
- Sub-module sio_rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index, any.
  - Implemented by a double-width rotate-and-priority-encode.
- The top module holds the FSM, shift register and counter.

Test Plan:
1. Reset, then req_vld=2'b01, req_data[0]=32'h44332211, rdy_tx=1 permanently -> req_rdy=01 in the first cycle; d_tx sequence 11,22,33,44 on consecutive cycles; busy high for 4 cycles; vld_tx=0 afterwards.
2. Backpressure: same word, rdy_tx toggled 1,0,0,1,0,1,1 -> exactly 4 handshakes; d_tx stable and vld_tx=1 during every rdy_tx=0 cycle; no byte lost or duplicated.
3. Both requesters held valid with words A0A0A0A0 and B1B1B1B1 -> grant order 0,1,0,1; gnt_id follows; byte stream never mixes A0 and B1 within a 4-byte group.
4. Requester 1 asserts during requester 0's SEND -> req_rdy[1]=0 until IDLE; granted on the first IDLE cycle; exactly one bubble cycle between words.
5. LSB_FIRST=0, word 32'hDEADBEEF -> bytes DE,AD,BE,EF.
6. rst asserted after the second byte of a word -> vld_tx/req_rdy/busy go to 0 immediately (async); after release with req_vld low, no further bytes and vld_tx stays 0.

Source files
------------

// File: rtl/sio_pkg.sv
// Shared types and helpers for the serial transmit scheduler.
package sio_pkg;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam int unsigned SIO_WIDTH = 32;
  localparam int unsigned BYTES     = SIO_WIDTH / 8;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sio_rr_pick.sv
// Combinational round-robin picker: the first request at or after ptr+1 wins,
// wrapping around; found by rotating the request vector and priority encoding.
module sio_rr_pick
  import sio_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]          i_req,
  input  logic [ptr_w(NREQ)-1:0]   i_ptr,
  output logic [NREQ-1:0]          o_gnt,
  output logic [ptr_w(NREQ)-1:0]   o_idx,
  output logic                     o_any
);

  localparam int unsigned PW = ptr_w(NREQ);

  logic [PW-1:0]   w_start;
  logic [PW-1:0]   w_off;
  logic [NREQ-1:0] w_rot;
  logic [PW:0]     w_sum;

  always_comb begin
    w_start = (i_ptr >= PW'(NREQ - 1)) ? '0 : i_ptr + 1'b1;
    // Doubling the vector makes the shift a rotate, so w_rot[0] is the start slot.
    w_rot   = NREQ'({i_req, i_req} >> w_start);
    w_off   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_rot[NREQ-1-k]) w_off = PW'(NREQ - 1 - k);
    end
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
    o_idx = w_sum[PW-1:0];
    o_any = |i_req;
    o_gnt = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/sio_tx_sched.sv
// Word-level transmit scheduler: grants whole words round-robin among NREQ
// producers and serializes each into bytes on a single valid/ready channel.
module sio_tx_sched
  import sio_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned WIDTH     = SIO_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_vld,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_rdy,
  output logic [7:0]                d_tx,
  output logic                      vld_tx,
  input  logic                      rdy_tx,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   gnt_id
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned PW     = ptr_w(NREQ);
  localparam int unsigned CW     = ptr_w(NBYTES);

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [WIDTH-1:0]        r_sh;
  logic [CW-1:0]           r_cnt;
  logic [PW-1:0]           r_ptr;
  logic [$clog2(NREQ)-1:0] r_gnt_id;

  logic [NREQ-1:0]         w_gnt;
  logic [PW-1:0]           w_idx;
  logic                    w_any;
  logic                    w_take;
  logic                    w_xfer;

  sio_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req (req_vld),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_take     = 1'b0;
    w_xfer     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_take     = 1'b1;
          w_state_nx = S_SEND;
        end
      end
      S_SEND: begin
        if (rdy_tx) begin
          w_xfer = 1'b1;
          if (r_cnt == '0) w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh     <= '0;
      r_cnt    <= '0;
      r_ptr    <= PW'(NREQ - 1);
      r_gnt_id <= '0;
    end else if (w_take) begin
      r_sh     <= req_data[w_idx*WIDTH +: WIDTH];
      r_cnt    <= CW'(NBYTES - 1);
      r_ptr    <= w_idx;
      r_gnt_id <= w_idx;
    end else if (w_xfer && (r_cnt != '0)) begin
      r_sh  <= LSB_FIRST ? (r_sh >> 8) : (r_sh << 8);
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // req_rdy is gated by rst so a pending request never sees a grant during reset.
  assign req_rdy = ((r_state == S_IDLE) && !rst) ? w_gnt : '0;
  assign vld_tx  = (r_state == S_SEND);
  assign busy    = (r_state == S_SEND);
  assign d_tx    = LSB_FIRST ? r_sh[7:0] : r_sh[WIDTH-1 -: 8];
  assign gnt_id  = r_gnt_id;

endmodule
